// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and pointer synchronisers.
// Functions take 32-bit zero-extended values; callers cast to their width.
package gray_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits make a full 32-bit prefix XOR correct for any narrower width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [31:0] cnt_max(input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[31:0];
  endfunction

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decode; bit i is the XOR of gray[WIDTH-1:i].
module gray_decode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updn_cntr.sv
// Up/down Gray counter with clear, binary/Gray load, optional saturation
// and a registered wrap pulse. All registered outputs derive from bin_next.
module gray_updn_cntr
  import gray_pkg::*;
#(
  parameter int          WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned INIT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV   = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_G = WIDTH'(bin2gray(32'(INIT)));

  logic [WIDTH-1:0] ld_dec;
  logic             wrap_next;

  gray_decode #(.WIDTH(WIDTH)) u_dec (
    .gray (load_val),
    .bin  (ld_dec)
  );

  // Saturation compares the current count, so the sum never needs a carry bit.
  always_comb begin
    bin_next  = bin;
    wrap_next = 1'b0;
    if (clr) begin
      bin_next = INIT_V;
    end else if (load) begin
      bin_next = load_is_gray ? ld_dec : load_val;
    end else if (inc && !dec) begin
      if (bin == MAXV) begin
        if (!SATURATE) begin
          bin_next  = '0;
          wrap_next = 1'b1;
        end
      end else begin
        bin_next = bin + 1'b1;
      end
    end else if (dec && !inc) begin
      if (bin == '0) begin
        if (!SATURATE) begin
          bin_next  = MAXV;
          wrap_next = 1'b1;
        end
      end else begin
        bin_next = bin - 1'b1;
      end
    end
  end

  assign gray_next = WIDTH'(bin2gray(32'(bin_next)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin    <= INIT_V;
      gray   <= INIT_G;
      at_max <= (INIT_V == MAXV);
      at_min <= (INIT_V == '0);
      wrap   <= 1'b0;
    end else begin
      bin    <= bin_next;
      gray   <= gray_next;
      at_max <= (bin_next == MAXV);
      at_min <= (bin_next == '0);
      wrap   <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_updn_cntr.sv
// Directed vector table plus corner sequences and a reference-model run
// over three counter configurations sharing one stimulus bus.
module tb_gray_updn_cntr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0, load = 1'b0, lig = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [15:0] lv = '0;

  always #5 clk = ~clk;

  logic [3:0] a_bin, a_gray, a_bn, a_gn; logic a_max, a_min, a_wrap;
  logic [3:0] b_bin, b_gray, b_bn, b_gn; logic b_max, b_min, b_wrap;
  logic [4:0] c_bin, c_gray, c_bn, c_gn; logic c_max, c_min, c_wrap;

  gray_updn_cntr #(.WIDTH(4), .SATURATE(1'b0), .INIT(5)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(lig),
    .load_val(lv[3:0]), .inc(inc), .dec(dec), .bin(a_bin), .gray(a_gray),
    .bin_next(a_bn), .gray_next(a_gn), .at_max(a_max), .at_min(a_min), .wrap(a_wrap));

  gray_updn_cntr #(.WIDTH(4), .SATURATE(1'b1), .INIT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(lig),
    .load_val(lv[3:0]), .inc(inc), .dec(dec), .bin(b_bin), .gray(b_gray),
    .bin_next(b_bn), .gray_next(b_gn), .at_max(b_max), .at_min(b_min), .wrap(b_wrap));

  gray_updn_cntr #(.WIDTH(5), .SATURATE(1'b0), .INIT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_is_gray(lig),
    .load_val(lv[4:0]), .inc(inc), .dec(dec), .bin(c_bin), .gray(c_gray),
    .bin_next(c_bn), .gray_next(c_gn), .at_max(c_max), .at_min(c_min), .wrap(c_wrap));

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, l, g, input logic [15:0] v, input logic i, d);
    clr = c; load = l; lig = g; lv = v; inc = i; dec = d;
  endtask

  // Reference: returns {wrap, next value}
  function automatic logic [16:0] mnext(input int w, input bit sat, input int init,
      input logic [15:0] cur, input logic c, l, g, input logic [15:0] v0, input logic i, d);
    logic [15:0] mx, v;
    mx = 16'((32'd1 << w) - 1);
    if (c) return {1'b0, 16'(init)};
    if (l) begin
      v = v0 & mx;
      if (g) for (int k = w - 2; k >= 0; k--) v[k] = v[k] ^ v[k+1];
      return {1'b0, v};
    end
    if (i && !d) begin
      if (cur == mx) return sat ? {1'b0, cur} : {1'b1, 16'd0};
      return {1'b0, cur + 16'd1};
    end
    if (d && !i) begin
      if (cur == 16'd0) return sat ? {1'b0, cur} : {1'b1, mx};
      return {1'b0, cur - 16'd1};
    end
    return {1'b0, cur};
  endfunction

  function automatic logic [63:0] pk(input int w, input logic [16:0] r);
    logic [15:0] v, mx;
    v  = r[15:0];
    mx = 16'((32'd1 << w) - 1);
    return {29'd0, r[16], v == mx, v == 16'd0, v ^ (v >> 1), v};
  endfunction

  typedef struct {
    logic c, l, g; logic [3:0] v; logic i, d;
    logic [3:0] eb, eg; logic ew, emax, emin;
    string nm;
  } vec_t;

  vec_t vt[16];

  initial begin
    logic [3:0] prev;
    logic [15:0] ma, mb, mc;
    logic [16:0] ra, rb, rc;
    logic c, l, g, i, d; logic [15:0] v;

    vt[0]  = '{0,1,0,4'd0, 0,0, 4'd0, 4'h0, 0,0,1, "ld0"};
    vt[1]  = '{0,0,0,4'd0, 0,1, 4'd15,4'h8, 1,1,0, "dn_wrap"};
    vt[2]  = '{0,0,0,4'd0, 1,0, 4'd0, 4'h0, 1,0,1, "up_wrap"};
    vt[3]  = '{0,0,0,4'd0, 1,0, 4'd1, 4'h1, 0,0,0, "inc1"};
    vt[4]  = '{0,1,1,4'hC, 0,0, 4'd8, 4'hC, 0,0,0, "ld_gray_c"};
    vt[5]  = '{0,1,0,4'd9, 0,1, 4'd9, 4'hD, 0,0,0, "ld_bin_dec"};
    vt[6]  = '{0,1,0,4'd7, 1,0, 4'd7, 4'h4, 0,0,0, "ld7_inc"};
    vt[7]  = '{0,0,0,4'd0, 1,1, 4'd7, 4'h4, 0,0,0, "hold_both"};
    vt[8]  = '{1,0,0,4'd0, 1,0, 4'd5, 4'h7, 0,0,0, "clr_inc"};
    vt[9]  = '{1,1,0,4'd2, 0,0, 4'd5, 4'h7, 0,0,0, "clr_pri"};
    vt[10] = '{0,1,0,4'd15,0,0, 4'd15,4'h8, 0,1,0, "ld15"};
    vt[11] = '{0,0,0,4'd0, 1,1, 4'd15,4'h8, 0,1,0, "hold_max"};
    vt[12] = '{0,0,0,4'd0, 0,0, 4'd15,4'h8, 0,1,0, "idle"};
    vt[13] = '{0,0,0,4'd0, 1,0, 4'd0, 4'h0, 1,0,1, "inc_wrap"};
    vt[14] = '{0,0,0,4'd0, 0,0, 4'd0, 4'h0, 0,0,1, "wrap_fall"};
    vt[15] = '{0,1,1,4'hF, 0,0, 4'd10,4'hF, 0,0,0, "ld_gray_f"};

    // Reset values
    #12;
    chk("rst_bin",  a_bin, 4'd5);
    chk("rst_gray", a_gray, 4'd7);
    chk("rst_flags", {a_max, a_min, a_wrap}, 3'b000);
    chk("rst_b_min", {b_max, b_min, b_wrap}, 3'b010);
    @(negedge clk); rst_n = 1'b1;
    tick();

    foreach (vt[k]) begin
      drive(vt[k].c, vt[k].l, vt[k].g, 16'(vt[k].v), vt[k].i, vt[k].d);
      tick();
      chk(vt[k].nm, {a_bin, a_gray, a_wrap, a_max, a_min},
          {vt[k].eb, vt[k].eg, vt[k].ew, vt[k].emax, vt[k].emin});
    end

    // Combinational next view
    drive(0,1,0,16'd3,0,0); tick();
    drive(0,0,0,16'd0,1,0); #1;
    chk("bin_next", a_bn, 4'd4);
    chk("gray_next", a_gn, 4'b0110);
    tick();
    chk("gray_after", a_gray, 4'b0110);

    // 17 increments from 0 through the wrap, one Gray bit per step
    drive(0,1,0,16'd0,0,0); tick();
    prev = a_gray;
    drive(0,0,0,16'd0,1,0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("one_bit", 64'($countones(a_gray ^ prev)), 64'd1);
      prev = a_gray;
      if (k == 15) chk("at15", {a_gray, a_max, a_wrap}, {4'h8, 1'b1, 1'b0});
      if (k == 16) chk("at16", {a_bin, a_wrap, a_min}, {4'd0, 1'b1, 1'b1});
      if (k == 17) chk("at17", {a_bin, a_wrap}, {4'd1, 1'b0});
    end

    // Saturation on u_b
    drive(1,0,0,16'd0,0,0); tick();
    drive(0,0,0,16'd0,0,1); tick();
    chk("sat_dn", {b_bin, b_wrap, b_min}, {4'd0, 1'b0, 1'b1});
    drive(0,1,0,16'd15,0,0); tick();
    drive(0,0,0,16'd0,1,0); tick();
    chk("sat_up", {b_bin, b_wrap, b_max}, {4'd15, 1'b0, 1'b1});
    drive(0,0,0,16'd0,0,1); tick();
    chk("sat_dn14", b_bin, 4'd14);

    // Asynchronous reset mid-count, right after a wrap
    drive(0,1,0,16'd15,0,0); tick();
    drive(0,0,0,16'd0,1,0); tick();
    #2 rst_n = 1'b0; #1;
    chk("mid_rst", {a_bin, a_gray, a_wrap, a_max, a_min}, {4'd5, 4'd7, 3'b000});
    drive(0,0,0,16'd0,0,0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Reference-model run over all three configurations
    ma = 16'd5; mb = 16'd0; mc = 16'd0;
    for (int n = 0; n < 3000; n++) begin
      c = ($urandom % 40) == 0; l = ($urandom % 12) == 0; g = 1'($urandom);
      v = 16'($urandom); i = 1'($urandom); d = 1'($urandom);
      drive(c, l, g, v, i, d); #1;
      ra = mnext(4, 1'b0, 5, ma, c, l, g, v, i, d);
      rb = mnext(4, 1'b1, 0, mb, c, l, g, v, i, d);
      rc = mnext(5, 1'b0, 0, mc, c, l, g, v, i, d);
      chk("rnd_next", {c_gn, c_bn, b_bn, a_bn},
          {rc[4:0] ^ (rc[4:0] >> 1), rc[4:0], rb[3:0], ra[3:0]});
      tick();
      chk("rnd_a", {29'd0, a_wrap, a_max, a_min, 12'd0, a_gray, 12'd0, a_bin}, pk(4, ra));
      chk("rnd_b", {29'd0, b_wrap, b_max, b_min, 12'd0, b_gray, 12'd0, b_bin}, pk(4, rb));
      chk("rnd_c", {29'd0, c_wrap, c_max, c_min, 11'd0, c_gray, 11'd0, c_bin}, pk(5, rc));
      ma = ra[15:0]; mb = rb[15:0]; mc = rc[15:0];
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
